// File: rtl/jump_early_dec_ras.sv
// Early jump decoder with an optional return-address stack.
// Resolves JAL and function returns one cycle after fetch, asks PC generation
// to redirect, and hands its prediction on to the issue stage.
// Optional feature macro: LEN5_EARLY_RAS_EN
//   defined   -> return-address stack present; a RET is predicted from the
//                stack top and is only early-jumped when the stack is non-empty.
//   undefined -> no stack storage; every RET early-jumps to rf_ra_value_i and
//                ras_count_o is tied to zero.
module jump_early_dec_ras #(
    parameter int XLEN      = 64,
    parameter int RAS_DEPTH = 8,
    parameter int LINK_X5   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [31:0]                  instr_i,
    input  logic                         instr_valid_i,
    input  logic                         issue_ready_i,
    input  logic [XLEN-1:0]              pred_pc_i,
    input  logic [XLEN-1:0]              pred_target_i,
    input  logic                         pred_taken_i,
    input  logic [XLEN-1:0]              early_jump_target_i,
    input  logic [XLEN-1:0]              rf_ra_value_i,
    output logic                         early_jump_valid_o,
    output logic                         mem_flush_o,
    output logic [XLEN-1:0]              early_jump_base_o,
    output logic [XLEN-1:0]              early_jump_offs_o,
    output logic [XLEN-1:0]              issue_pred_pc_o,
    output logic [XLEN-1:0]              issue_pred_target_o,
    output logic                         issue_pred_taken_o,
    output logic [$clog2(RAS_DEPTH):0]   ras_count_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    typedef enum logic {
        IDLE,
        WAIT_ISSUE
    } state_t;

    state_t state_reg, state_next;

    // Instruction fields
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [11:0] imm_i;

    assign opcode = instr_i[6:0];
    assign rd     = instr_i[11:7];
    assign funct3 = instr_i[14:12];
    assign rs1    = instr_i[19:15];
    assign imm_i  = instr_i[31:20];

    logic rd_is_link;
    logic rs1_is_link;
    logic is_call;
    logic is_jal;
    logic is_ret;
    logic ras_nonempty;
    logic is_jump;

    logic [XLEN-1:0] j_imm;
    logic [XLEN-1:0] ret_offs;
    logic            valid_int;
    logic            mflush_int;

    assign rd_is_link  = (rd == 5'd1)  || ((LINK_X5 != 0) && (rd == 5'd5));
    assign rs1_is_link = (rs1 == 5'd1) || ((LINK_X5 != 0) && (rs1 == 5'd5));

    assign is_call = (opcode == OPC_JAL) && rd_is_link;
    assign is_jal  = (opcode == OPC_JAL) && !rd_is_link;
    assign is_ret  = (opcode == OPC_JALR) && (funct3 == 3'b000) && (imm_i == 12'd0)
                     && (rd == 5'd0) && rs1_is_link;

    // A return is only worth redirecting when we actually know where it goes
    assign is_jump = is_call || is_jal || (is_ret && ras_nonempty);

    // J-type immediate, sign-extended to the full address width
    assign j_imm = {{(XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20],
                    instr_i[30:21], 1'b0};

`ifdef LEN5_EARLY_RAS_EN
    // Circular stack: ptr_reg indexes the current top; count saturates at depth
    logic [XLEN-1:0]  ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_reg, ptr_next, ptr_inc;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             commit;
    logic             push;
    logic             pop;

    assign ptr_inc      = ptr_reg + PTR_W'(1);
    assign ras_nonempty = (cnt_reg != '0);
    assign ret_offs     = ras_mem[ptr_reg];
    assign commit       = mflush_int && !flush_i;
    assign push         = commit && is_call;
    assign pop          = commit && is_ret;

    // Pointer/count update; a push onto a full stack lands on the oldest slot
    always_comb begin
        ptr_next = ptr_reg;
        cnt_next = cnt_reg;
        if (push) begin
            ptr_next = ptr_inc;
            if (cnt_reg != CNT_W'(RAS_DEPTH)) begin
                cnt_next = cnt_reg + CNT_W'(1);
            end
        end else if (pop) begin
            ptr_next = ptr_reg - PTR_W'(1);
            cnt_next = cnt_reg - CNT_W'(1);
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_reg <= '0;
            cnt_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            cnt_reg <= cnt_next;
        end
    end

    // Stack storage: written on a committed call, never cleared
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            ras_mem[ptr_inc] <= pred_pc_i + XLEN'(4);
        end
    end

    assign ras_count_o = rst_ni ? cnt_reg : '0;
`else
    assign ras_nonempty = 1'b1;
    assign ret_offs     = rf_ra_value_i;
    assign ras_count_o  = '0;
`endif

    // Redirect handshake: hold the request until issue takes the jump
    always_comb begin
        state_next = state_reg;
        valid_int  = 1'b0;
        mflush_int = 1'b0;
        case (state_reg)
            IDLE: begin
                valid_int  = instr_valid_i && is_jump;
                mflush_int = valid_int && issue_ready_i;
                if (valid_int && !issue_ready_i) begin
                    state_next = WAIT_ISSUE;
                end
            end
            WAIT_ISSUE: begin
                valid_int  = 1'b1;
                mflush_int = issue_ready_i;
                if (issue_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (flush_i) begin
            state_next = IDLE;
        end
        // Requests are suppressed while reset is held
        if (!rst_ni) begin
            valid_int  = 1'b0;
            mflush_int = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Target components handed to PC generation
    always_comb begin
        early_jump_base_o = pred_pc_i;
        early_jump_offs_o = j_imm;
        if (is_ret) begin
            early_jump_base_o = '0;
            early_jump_offs_o = ret_offs;
        end
    end

    assign early_jump_valid_o  = valid_int;
    assign mem_flush_o         = mflush_int;
    assign issue_pred_pc_o     = pred_pc_i;
    assign issue_pred_target_o = is_jump ? early_jump_target_i : pred_target_i;
    assign issue_pred_taken_o  = is_jump || pred_taken_i;

endmodule
